// File: rtl/btb_resolve_controller.sv
// btb_resolve_controller: resolves EX control flow, redirects fetch on mispredict and maintains the BTB
module btb_resolve_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic [31:0] ex_pred_pc,
  input  logic        invalidate_req,
  output logic        flush,
  output logic [31:0] pc_redirect,
  output logic        fetch_stall,
  output logic        btb_we,
  output logic [4:0]  btb_idx,
  output logic [24:0] btb_tag,
  output logic [31:0] btb_target,
  output logic [15:0] mispredict_count
);
  typedef enum logic [1:0] {SWEEP, RUN, SQUASH} state_t;
  state_t      state, state_n;
  logic [4:0]  sweep_idx;
  logic        wr_valid;
  logic [4:0]  wr_idx;
  logic [24:0] wr_tag;
  logic [31:0] wr_target;
  logic [15:0] count;
  logic [31:0] seq_pc, actual_next;
  logic        mispredict, sweep, insert;
  // Resolution, next state and outputs; reset forces the quiescent sweep-entry outputs
  always_comb begin
    seq_pc      = ex_pc + 32'd4;
    actual_next = (ex_is_jump || (ex_is_branch && ex_taken)) ? ex_target : seq_pc;
    insert      = actual_next != seq_pc;
    mispredict  = reset && state == RUN && ex_valid && actual_next != ex_pred_pc;
    sweep       = state == SWEEP;
    state_n     = sweep ? (&sweep_idx ? RUN : SWEEP) :
                  invalidate_req ? SWEEP :
                  mispredict ? SQUASH : RUN;
    flush       = !reset || sweep || mispredict;
    fetch_stall = !reset || sweep;
    pc_redirect = mispredict ? actual_next : 32'd0;
    btb_we      = reset && (sweep || wr_valid);
    btb_idx     = !reset ? 5'd0 : sweep ? sweep_idx : wr_valid ? wr_idx : 5'd0;
    btb_tag     = (reset && !sweep && wr_valid) ? wr_tag : 25'd0;
    btb_target  = (reset && !sweep && wr_valid) ? wr_target : 32'd0;
    mispredict_count = count;
  end
  // State, sweep index, registered BTB update and saturating mispredict counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SWEEP;
      sweep_idx <= 5'd0;
      wr_valid  <= 1'b0;
      wr_idx    <= 5'd0;
      wr_tag    <= 25'd0;
      wr_target <= 32'd0;
      count     <= 16'd0;
    end else begin
      state     <= state_n;
      sweep_idx <= sweep ? sweep_idx + 5'd1 : 5'd0;
      wr_valid  <= mispredict && !invalidate_req;
      if (mispredict) begin
        wr_idx    <= ex_pc[6:2];
        wr_tag    <= insert ? ex_pc[31:7] : 25'd0;
        wr_target <= insert ? actual_next : 32'd0;
        if (count != 16'hffff) count <= count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_btb_resolve_controller.sv
// tb_btb_resolve_controller: randomized and directed checks against a behavioural model
module tb_btb_resolve_controller;
  logic        clk = 1'b0, reset = 1'b0;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_pc = 32'd0, ex_target = 32'd0, ex_pred_pc = 32'd0;
  logic        invalidate_req = 1'b0;
  logic        flush, fetch_stall, btb_we;
  logic [31:0] pc_redirect, btb_target;
  logic [4:0]  btb_idx;
  logic [24:0] btb_tag;
  logic [15:0] mispredict_count;
  int errors = 0, checks = 0;
  int sweep_pos = 0;
  bit in_squash = 0, pend = 0;
  logic [4:0]  p_idx;
  logic [24:0] p_tag;
  logic [31:0] p_tgt;
  int cnt = 0;

  btb_resolve_controller dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_pc(ex_pred_pc), .invalidate_req(invalidate_req), .flush(flush),
    .pc_redirect(pc_redirect), .fetch_stall(fetch_stall), .btb_we(btb_we), .btb_idx(btb_idx),
    .btb_tag(btb_tag), .btb_target(btb_target), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] resolved();
    return (ex_is_jump || (ex_is_branch && ex_taken)) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic step();
    logic [31:0] an, e_idx, e_tag, e_tgt;
    bit mp, e_flush, e_stall, e_we;
    #3;
    an = resolved();
    mp = reset && sweep_pos < 0 && !in_squash && ex_valid && an != ex_pred_pc;
    if (!reset) begin
      e_flush = 1; e_stall = 1; e_we = 0; e_idx = 0; e_tag = 0; e_tgt = 0;
    end else if (sweep_pos >= 0) begin
      e_flush = 1; e_stall = 1; e_we = 1; e_idx = sweep_pos; e_tag = 0; e_tgt = 0;
    end else begin
      e_flush = mp; e_stall = 0; e_we = pend;
      e_idx = pend ? 32'(p_idx) : 0;
      e_tag = pend ? 32'(p_tag) : 0;
      e_tgt = pend ? p_tgt : 0;
    end
    chk("flush", 32'(flush), 32'(e_flush));
    chk("fetch_stall", 32'(fetch_stall), 32'(e_stall));
    chk("pc_redirect", pc_redirect, mp ? an : 32'd0);
    chk("btb_we", 32'(btb_we), 32'(e_we));
    chk("btb_idx", 32'(btb_idx), e_idx);
    chk("btb_tag", 32'(btb_tag), e_tag);
    chk("btb_target", btb_target, e_tgt);
    chk("mispredict_count", 32'(mispredict_count), cnt);
    @(posedge clk);
    if (!reset) begin
      sweep_pos = 0; in_squash = 0; pend = 0; cnt = 0;
    end else if (sweep_pos >= 0) begin
      sweep_pos = sweep_pos == 31 ? -1 : sweep_pos + 1;
      pend = 0;
    end else begin
      pend = mp && !invalidate_req;
      if (mp) begin
        p_idx = ex_pc[6:2];
        p_tag = (an != ex_pc + 32'd4) ? ex_pc[31:7] : 25'd0;
        p_tgt = (an != ex_pc + 32'd4) ? an : 32'd0;
        cnt = cnt < 65535 ? cnt + 1 : 65535;
      end
      if (invalidate_req) begin
        sweep_pos = 0; in_squash = 0;
      end else in_squash = mp;
    end
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; invalidate_req = 0;
  endtask

  task automatic branch(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                        input logic [31:0] pred, input bit inv);
    ex_valid = 1; ex_is_branch = 1; ex_is_jump = 0; ex_taken = tk;
    ex_pc = pc; ex_target = tgt; ex_pred_pc = pred; invalidate_req = inv;
  endtask

  task automatic rand_inputs();
    logic [31:0] an;
    ex_valid = $urandom_range(0, 3) != 0;
    ex_is_branch = 1'($urandom);
    ex_is_jump = !ex_is_branch && $urandom_range(0, 3) == 0;
    ex_taken = 1'($urandom);
    ex_pc = $urandom & 32'hffff_fffc;
    ex_target = $urandom_range(0, 3) == 0 ? ex_pc + 32'd4 : $urandom & 32'hffff_fffc;
    an = resolved();
    ex_pred_pc = $urandom_range(0, 1) ? an : ($urandom_range(0, 1) ? ex_pc + 32'd4 : ex_target);
    invalidate_req = $urandom_range(0, 39) == 0;
    reset = $urandom_range(0, 149) != 0;
  endtask

  initial begin
    @(posedge clk); #1;
    repeat (3) step();
    reset = 1;
    repeat (34) step();
    branch(32'h100, 32'h200, 1, 32'h104, 0); step();
    idle(); step();
    branch(32'h1c, 32'h80, 0, 32'h80, 0); step();
    idle(); step();
    branch(32'h300, 32'h400, 1, 32'h304, 0); step();
    branch(32'h500, 32'h600, 1, 32'h504, 0); step();
    idle(); step();
    branch(32'h700, 32'h800, 1, 32'h704, 1); step();
    idle(); repeat (34) step();
    branch(32'h900, 32'ha00, 1, 32'h904, 0); step();
    invalidate_req = 1; step();
    repeat (10) step();
    reset = 0; step(); reset = 1;
    idle(); repeat (34) step();
    repeat (3000) begin rand_inputs(); step(); end
    reset = 1; idle(); repeat (34) step();
    force dut.count = 16'hfffd;
    #1 release dut.count;
    cnt = 65533;
    repeat (8) begin branch(32'h1000, 32'h2000, 1, 32'h1004, 0); step(); end
    idle(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
